// File: rtl/temporal_ngram_encoder_v2.sv
// temporal_ngram_encoder_v2: binds runtime-sized N-grams of spatial hypervectors,
// forwarding each as a query (predict) or bundling them per label (train/update).
// Ports:
//   Clk_CI, Reset_RI            clock, synchronous active-high reset
//   ValidIn_SI/ReadyOut_SO      input handshake
//   ModeIn_SI, LabelIn_DI       segment mode (0/3 predict, 1 train, 2 update) and label
//   NGramSize_SI                N (0 or >MAX_NGRAM clamps to MAX_NGRAM)
//   HypervectorIn_DI            spatial hypervector
//   ValidOut_SO/ReadyIn_SI      output handshake
//   ModeOut_SO, LabelOut_DO     mode/label of the emitted vector
//   CountOut_DO                 N-grams bundled into the emitted vector
//   HypervectorOut_DO           emitted vector
//   SaturatedOut_SO             bundle counter saturated in the emitted segment
module temporal_ngram_encoder_v2 #(
    parameter int HV_DIM    = 2000,
    parameter int MAX_NGRAM = 5,
    parameter int NGRAM_W   = 3,
    parameter int LABEL_W   = 5,
    parameter int CNT_W     = 8
) (
    input  logic               Clk_CI,
    input  logic               Reset_RI,
    input  logic               ValidIn_SI,
    output logic               ReadyOut_SO,
    input  logic [1:0]         ModeIn_SI,
    input  logic [LABEL_W-1:0] LabelIn_DI,
    input  logic [NGRAM_W-1:0] NGramSize_SI,
    input  logic [HV_DIM-1:0]  HypervectorIn_DI,
    output logic               ValidOut_SO,
    input  logic               ReadyIn_SI,
    output logic [1:0]         ModeOut_SO,
    output logic [LABEL_W-1:0] LabelOut_DO,
    output logic [CNT_W-1:0]   CountOut_DO,
    output logic [HV_DIM-1:0]  HypervectorOut_DO,
    output logic               SaturatedOut_SO
);
    typedef enum logic [1:0] {ACCEPT, EMIT_SEG, EMIT_Q, CLEAR} state_t;

    localparam logic [NGRAM_W-1:0] NMAX = NGRAM_W'(MAX_NGRAM);

    state_t             state, state_nxt;
    logic [HV_DIM-1:0]  hist [1:MAX_NGRAM-1];
    logic [CNT_W-1:0]   cnt [HV_DIM];
    logic [CNT_W-1:0]   bcnt;
    logic               sat;
    logic [NGRAM_W-1:0] fill, seg_n, n_in, n_eff;
    logic [1:0]         seg_mode, mode_in, m_eff;
    logic [LABEL_W-1:0] seg_label, l_eff;
    logic               seg_open, boundary, acc, produce, bsat;
    logic [HV_DIM-1:0]  ngram, maj;

    // bit index 0 is the MSB, so the spec's rotate is a right shift in SV order
    function automatic logic [HV_DIM-1:0] rot(input logic [HV_DIM-1:0] v);
        return {v[0], v[HV_DIM-1:1]};
    endfunction

    assign mode_in  = (ModeIn_SI == 2'd3) ? 2'd0 : ModeIn_SI;
    assign n_in     = (NGramSize_SI == '0 || NGramSize_SI > NMAX) ? NMAX : NGramSize_SI;
    // before the first input of a segment the live inputs define it
    assign n_eff    = seg_open ? seg_n : n_in;
    assign m_eff    = seg_open ? seg_mode : mode_in;
    assign l_eff    = seg_open ? seg_label : LabelIn_DI;
    assign boundary = state == ACCEPT && ValidIn_SI && seg_open &&
                      (LabelIn_DI != seg_label || mode_in != seg_mode);
    assign ReadyOut_SO = state == ACCEPT && !boundary;
    assign acc      = ValidIn_SI && ReadyOut_SO;
    // fill saturates at N-1, after which every input completes an N-gram
    assign produce  = fill == n_eff - NGRAM_W'(1);
    assign bsat     = bcnt == '1;

    always_comb begin
        ngram = HypervectorIn_DI;
        for (int k = 1; k < MAX_NGRAM; k++)
            if (k < int'(n_eff)) ngram = ngram ^ hist[k];
    end

    // strict majority: ties resolve to 0
    always_comb begin
        maj = '0;
        for (int i = 0; i < HV_DIM; i++)
            maj[i] = {cnt[i], 1'b0} > {1'b0, bcnt};
    end

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) state <= ACCEPT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ACCEPT)
            state_nxt = boundary ? (bcnt != '0 ? EMIT_SEG : CLEAR)
                                 : (acc && produce && m_eff == 2'd0 ? EMIT_Q : ACCEPT);
        else if (state == EMIT_SEG)
            state_nxt = ReadyIn_SI ? CLEAR : EMIT_SEG;
        else if (state == EMIT_Q)
            state_nxt = ReadyIn_SI ? ACCEPT : EMIT_Q;
        else
            state_nxt = ACCEPT;
    end

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            ValidOut_SO       <= 1'b0;
            ModeOut_SO        <= '0;
            LabelOut_DO       <= '0;
            CountOut_DO       <= '0;
            HypervectorOut_DO <= '0;
            SaturatedOut_SO   <= 1'b0;
            for (int k = 1; k < MAX_NGRAM; k++) hist[k] <= '0;
            for (int i = 0; i < HV_DIM; i++) cnt[i] <= '0;
            bcnt      <= '0;
            sat       <= 1'b0;
            fill      <= '0;
            seg_n     <= '0;
            seg_mode  <= 2'd0;
            seg_label <= '0;
            seg_open  <= 1'b0;
        end else begin
            if (ValidOut_SO && ReadyIn_SI) ValidOut_SO <= 1'b0;
            if (state == CLEAR) begin
                for (int k = 1; k < MAX_NGRAM; k++) hist[k] <= '0;
                for (int i = 0; i < HV_DIM; i++) cnt[i] <= '0;
                bcnt     <= '0;
                sat      <= 1'b0;
                fill     <= '0;
                seg_open <= 1'b0;
            end
            if (boundary && bcnt != '0) begin
                ValidOut_SO       <= 1'b1;
                HypervectorOut_DO <= maj;
                CountOut_DO       <= bcnt;
                LabelOut_DO       <= seg_label;
                ModeOut_SO        <= seg_mode;
                SaturatedOut_SO   <= sat;
            end
            if (acc) begin
                seg_open  <= 1'b1;
                seg_n     <= n_eff;
                seg_mode  <= m_eff;
                seg_label <= l_eff;
                hist[1]   <= rot(HypervectorIn_DI);
                for (int k = 2; k < MAX_NGRAM; k++) hist[k] <= rot(hist[k-1]);
                if (!produce) fill <= fill + NGRAM_W'(1);
                if (produce && m_eff == 2'd0) begin
                    ValidOut_SO       <= 1'b1;
                    HypervectorOut_DO <= ngram;
                    CountOut_DO       <= CNT_W'(1);
                    LabelOut_DO       <= l_eff;
                    ModeOut_SO        <= 2'd0;
                    SaturatedOut_SO   <= 1'b0;
                end
                if (produce && m_eff != 2'd0) begin
                    if (bsat) sat <= 1'b1;
                    else begin
                        bcnt <= bcnt + CNT_W'(1);
                        for (int i = 0; i < HV_DIM; i++) cnt[i] <= cnt[i] + CNT_W'(ngram[i]);
                    end
                end
            end
        end
    end
endmodule

// File: doc/temporal_ngram_encoder_v2.md
Name: temporal_ngram_encoder_v2

Overview:
- Parametrised successor of the fixed-size temporal encoder. Sits between the spatial encoder and the associative memory.
- N-gram size is runtime-selectable up to MAX_NGRAM. Bundling is done in-block with per-bit saturating counters plus exact majority, so no external bundler is needed.
- Train/update segments are bundled per label. In predict mode, every full N-gram is forwarded as a query.

Parameters:
- HV_DIM, 2000, hypervector width; bit index 0 is the leftmost bit.
- MAX_NGRAM, 5, maximum N-gram length (>=2).
- NGRAM_W, 3, width of NGramSize_SI; must satisfy 2^NGRAM_W > MAX_NGRAM.
- LABEL_W, 5, label width.
- CNT_W, 8, width of the per-bit counters and of the bundle counter.

Ports:
- Clk_CI  in  1  clock.
- Reset_RI  in  1  synchronous, active-high reset.
- ValidIn_SI  in  1  input valid.
- ReadyOut_SO  out  1  block can accept input.
- ModeIn_SI  in  2  0=predict, 1=train, 2=update, 3=treated as predict.
- LabelIn_DI  in  LABEL_W  segment label.
- NGramSize_SI  in  NGRAM_W  N, legal range 1..MAX_NGRAM; 0 or >MAX_NGRAM is clamped to MAX_NGRAM.
- HypervectorIn_DI  in  HV_DIM  spatial hypervector.
- ValidOut_SO  out  1  output valid.
- ReadyIn_SI  in  1  downstream ready.
- ModeOut_SO  out  2  mode of the emitted vector.
- LabelOut_DO  out  LABEL_W  label of the emitted vector.
- CountOut_DO  out  CNT_W  number of N-grams bundled (1 in predict mode).
- HypervectorOut_DO  out  HV_DIM  emitted vector.
- SaturatedOut_SO  out  1  bundle counter saturated in the emitted segment.

Behaviour:
- Transfers: an input transfer occurs when ValidIn_SI & ReadyOut_SO; an output transfer occurs when ValidOut_SO & ReadyIn_SI.
- Output hold: all outputs are registered. They stay stable while ValidOut_SO=1 and ReadyIn_SI=0.
- Reset values:
  - ReadyOut_SO=1, ValidOut_SO=0.
  - ModeOut_SO=0, LabelOut_DO=0, CountOut_DO=0, HypervectorOut_DO=0, SaturatedOut_SO=0.
  - All history registers, per-bit counters, fill counter and bundle counter are 0.
  - FSM in ACCEPT; segment mode register = predict.
  - Reset mid-operation discards any pending output and partial segment.
- History: H[k], k=1..MAX_NGRAM-1. On each accepted input:
  - H[1] <= rot(HypervectorIn_DI).
  - H[k] <= rot(H[k-1]).
  - rot(v): new[0]=v[HV_DIM-1], new[i]=v[i-1] (a right-rotate when written MSB-first).
- Binding: ngram = HypervectorIn_DI XOR H[1] XOR ... XOR H[N-1]. Histories with k>=N are ignored.
- Segment start: occurs after reset or a segment flush.
  - N, mode and label are latched from the first accepted input.
  - Changes to NGramSize_SI mid-segment have no effect.
- Fill: the first N-1 accepted inputs of a segment only fill the history. The N-th and later inputs each produce an N-gram. For N=1, every input produces one.
- Train/update mode (latched):
  - Each produced N-gram: per-bit counter C[i] += ngram[i]; bundle counter B += 1.
  - If B = 2^CNT_W-1, further N-grams are dropped and the saturation flag is set.
  - A segment boundary is an accepted-cycle-candidate input (ValidIn_SI=1) whose label or mode differs from the latched values.
- Boundary handling:
  - The triggering input is not consumed: ReadyOut_SO=0 in the boundary cycle.
  - If B>0, the FSM goes to EMIT_SEG. Outputs are loaded the next cycle:
    - HypervectorOut_DO[i] = (2*C[i] > B); ties give 0.
    - CountOut_DO=B; label/mode are the latched values; SaturatedOut_SO=flag.
  - If B=0 (segment shorter than N): no output. The FSM spends one CLEAR cycle, then returns to ACCEPT.
  - After the output transfer in EMIT_SEG: go to CLEAR (counters, history, fill, B and flag zeroed), then ACCEPT. The triggering input is accepted in ACCEPT.
- Predict mode:
  - Each produced N-gram is loaded to the output the cycle after acceptance, with CountOut_DO=1. The FSM enters EMIT_Q with ReadyOut_SO=0 until the output transfer, then returns to ACCEPT.
  - The history persists across queries.
  - A mode or label change ends the segment through CLEAR with no output (B=0 in predict mode).
- States and transitions:
  - ACCEPT: to EMIT_SEG, CLEAR or EMIT_Q.
  - EMIT_SEG: holds until ReadyIn_SI, then CLEAR.
  - EMIT_Q: holds until ReadyIn_SI, then ACCEPT.
  - CLEAR: one cycle, then ACCEPT.
  - ReadyOut_SO=1 only in ACCEPT and not in a boundary cycle.
- Latency: input to predict output is 1 cycle. Boundary to segment output is 1 cycle.

Test Plan:
- Reset: Reset_RI=1 for 2 cycles -> ReadyOut_SO=1, ValidOut_SO=0, all data outputs 0.
- Predict, HV_DIM=8, N=3: inputs 0x01, 0x02, 0x04 -> exactly one output, cycle after third accept, HypervectorOut_DO=0x45, CountOut_DO=1.
- Train, N=1, label 3: inputs 0xF0, 0xF0, 0x0F, then label 5 -> ReadyOut_SO=0 on the label-5 cycle. Next cycle ValidOut_SO=1, HypervectorOut_DO=0xF0, CountOut_DO=3, LabelOut_DO=3. The label-5 input is accepted two cycles after the output transfer.
- Tie and saturation:
  - Train, N=1: inputs 0xFF, 0x00, then label change -> HypervectorOut_DO=0x00, CountOut_DO=2.
  - With CNT_W=2 and 5 inputs of 0xFF -> CountOut_DO=3, SaturatedOut_SO=1, HypervectorOut_DO=0xFF.
- Backpressure: hold ReadyIn_SI=0 for 5 cycles during EMIT_SEG -> outputs constant, ReadyOut_SO=0 throughout. Transfer on the first ReadyIn_SI=1.
- Short segment: N=4, train, 2 inputs, then label change -> no ValidOut_SO. One CLEAR cycle with ReadyOut_SO=0, then the new-label input is accepted. Asserting reset mid-EMIT_SEG -> ValidOut_SO=0 on the next cycle.
